// File: rtl/mux_arbitro_forzado_pkg.sv
// Shared definitions for the forced / round-robin output mux: state encoding and default sizes.
package mux_arbitro_forzado_pkg;

  typedef enum logic {
    S_FORZADO = 1'b0,
    S_RR      = 1'b1
  } state_t;

  localparam int N_CH_DEF   = 4;
  localparam int W_DEF      = 8;
  localparam int CTRL_W_DEF = 4;

endpackage

// File: rtl/mux_arbitro_forzado_arbitro_rr.sv
// Rotate-priority encoder: first valid channel at or after ptr, wrapping modulo N_CH.
module arbitro_rr
  import mux_arbitro_forzado_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic [N_CH-1:0]   valid_in,
  input  logic [CTRL_W-1:0] ptr,
  output logic [CTRL_W-1:0] idx,
  output logic              any
);

  // scan offsets 0..N_CH-1 from ptr; the first hit wins
  always_comb begin
    idx = {CTRL_W{1'b0}};
    any = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        logic hit;
        hit = !any && valid_in[i] && (((int'(ptr) + k) % N_CH) == i);
        idx = hit ? CTRL_W'(i) : idx;
        any = any | hit;
      end
    end
  end

endmodule

// File: rtl/mux_arbitro_forzado.sv
// N-channel mux from source FIFOs to one sink, forced or round-robin, registered output.
// Optional sticky starvation/out-of-range flag ERR when MUX_ERR_EN is defined.
module mux_arbitro_forzado
  import mux_arbitro_forzado_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int W      = W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MODE,
  input  logic [CTRL_W-1:0] CONTROL,
  input  logic [N_CH-1:0]   VALID_IN,
  input  logic [N_CH*W-1:0] DATA_IN,
  input  logic              READY_OUT,
  output logic [N_CH-1:0]   POP,
  output logic [W-1:0]      OUT,
  output logic              VALID,
`ifdef MUX_ERR_EN
  output logic              ERR,
`endif
  output logic [CTRL_W-1:0] GRANT_IDX
);

  state_t            state_r;
  logic [CTRL_W-1:0] ptr_r;
  logic [CTRL_W-1:0] rr_idx_s;
  logic              rr_any_s;
  logic [CTRL_W-1:0] cand_s;
  logic              cand_valid_s;
  logic [W-1:0]      cand_data_s;
  logic              fire_s;
  logic [N_CH-1:0]   pop_s;
  logic [CTRL_W-1:0] ptr_next_s;

  arbitro_rr #(.N_CH(N_CH), .CTRL_W(CTRL_W)) u_arbitro_rr (
    .valid_in (VALID_IN),
    .ptr      (ptr_r),
    .idx      (rr_idx_s),
    .any      (rr_any_s)
  );

  // candidate select; an out-of-range CONTROL matches no channel, so it never fires
  always_comb begin
    cand_s       = (state_r == S_RR) ? rr_idx_s : CONTROL;
    cand_valid_s = 1'b0;
    cand_data_s  = {W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cand_valid_s = cand_valid_s | ((cand_s == CTRL_W'(i)) & VALID_IN[i]);
      cand_data_s  = cand_data_s | ({W{cand_s == CTRL_W'(i)}} & DATA_IN[i*W +: W]);
    end
    fire_s = READY_OUT & cand_valid_s & ~RESET & ((state_r == S_FORZADO) | rr_any_s);
    pop_s  = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      pop_s[i] = fire_s & (cand_s == CTRL_W'(i));
    end
    ptr_next_s = (cand_s == CTRL_W'(N_CH - 1)) ? {CTRL_W{1'b0}} : cand_s + CTRL_W'(1);
  end

  assign POP = pop_s;

  // mode state, output registers and round-robin pointer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= S_FORZADO;
      ptr_r     <= {CTRL_W{1'b0}};
      OUT       <= {W{1'b0}};
      VALID     <= 1'b0;
      GRANT_IDX <= {CTRL_W{1'b0}};
    end else begin
      state_r <= MODE ? S_RR : S_FORZADO;
      VALID   <= fire_s;
      if (fire_s) begin
        OUT       <= cand_data_s;
        GRANT_IDX <= cand_s;
      end
      if (fire_s && (state_r == S_RR)) begin
        ptr_r <= ptr_next_s;
      end
    end
  end

`ifdef MUX_ERR_EN
  logic err_cond_s;

  // forced channel out of range, or empty while another channel waits
  always_comb begin
    err_cond_s = (state_r == S_FORZADO) & READY_OUT &
                 ((32'(CONTROL) >= 32'(N_CH)) | (~cand_valid_s & (|VALID_IN)));
  end

  // sticky until reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ERR <= 1'b0;
    end else begin
      ERR <= ERR | err_cond_s;
    end
  end
`endif

endmodule
